adc_buffer_sequencer: RTL and testbench

ADC_BUFFER_SEQUENCER -- requirements
Module: adc_buffer_sequencer

---
 rtl/adc_pkg.sv | 13 +
 rtl/adc_sample_timer.sv | 27 ++
 rtl/adc_buffer_sequencer.sv | 125 ++++++++++++
 tb/tb_adc_buffer_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC ring-buffer sequencer.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        FETCH     = 2'd2,
        WRITE     = 2'd3
    } adc_state_t;

    localparam logic [3:0] BRAM_WE_ALL = 4'b1111;

endpackage

// File: rtl/adc_sample_timer.sv
// Down-counting sample-period timer: load sets the count, tick fires at zero and reloads.
module adc_sample_timer #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                run,
    input  logic [DIV_BITS-1:0] period,
    output logic                tick
);

    logic [DIV_BITS-1:0] cnt;

    assign tick = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= period;
        end else if (run) begin
            cnt <= cnt - DIV_BITS'(1);
        end
    end

endmodule

// File: rtl/adc_buffer_sequencer.sv
// Paces ADC samples from a valid/ready source into a BRAM ring buffer,
// tracking producer index, sample count and sticky overrun/late flags.
module adc_buffer_sequencer
    import adc_pkg::*;
#(
    parameter int ADC_BITS       = 10,
    parameter int BRAM_ADDR_BITS = 32,
    parameter int DIV_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [DIV_BITS-1:0]       period_i,
    input  logic                      sample_valid_i,
    input  logic [31:0]               sample_data_i,
    output logic                      sample_ready_o,
    output logic [BRAM_ADDR_BITS-1:0] bram_addr_o,
    output logic [31:0]               bram_din_o,
    output logic                      bram_en_o,
    output logic [3:0]                bram_we_o,
    output logic [ADC_BITS-1:0]       ADC_buffer_prod_out,
    input  logic [ADC_BITS-1:0]       ADC_buffer_cons_in,
    output logic                      overrun_o,
    output logic                      late_o,
    output logic [31:0]               sample_count_o
);

    adc_state_t          state, state_nxt;
    logic [31:0]         data_q;
    logic [ADC_BITS-1:0] prod_inc;
    logic                full;
    logic                tick;
    logic                timer_load;
    logic                handshake;

    assign prod_inc   = ADC_buffer_prod_out + ADC_BITS'(1);
    assign full       = (prod_inc == ADC_buffer_cons_in);
    assign timer_load = (state == IDLE) && enable_i;
    assign handshake  = sample_ready_o && sample_valid_i;

    adc_sample_timer #(.DIV_BITS(DIV_BITS)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .run    (state != IDLE),
        .period (period_i),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (enable_i) state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (!enable_i)  state_nxt = IDLE;
                else if (tick)  state_nxt = FETCH;
            end
            FETCH: begin
                if (!enable_i)          state_nxt = IDLE;
                else if (sample_valid_i) state_nxt = WRITE;
            end
            WRITE:     state_nxt = enable_i ? WAIT_TICK : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Ready and write strobes are masked by reset/clear so a same-cycle
    // reset or clear can never complete a handshake or BRAM write.
    always_comb begin
        sample_ready_o = 1'b0;
        bram_en_o      = 1'b0;
        bram_we_o      = 4'b0000;
        bram_addr_o    = '0;
        bram_din_o     = '0;
        if (reset && !clear_i) begin
            if (state == FETCH && enable_i) begin
                sample_ready_o = 1'b1;
            end
            if (state == WRITE && !full) begin
                bram_en_o   = 1'b1;
                bram_we_o   = BRAM_WE_ALL;
                bram_addr_o = BRAM_ADDR_BITS'({ADC_buffer_prod_out, 2'b00});
                bram_din_o  = data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ADC_buffer_prod_out <= '0;
            sample_count_o      <= '0;
            overrun_o           <= 1'b0;
            late_o              <= 1'b0;
            data_q              <= '0;
        end else if (clear_i) begin
            ADC_buffer_prod_out <= '0;
            sample_count_o      <= '0;
            overrun_o           <= 1'b0;
            late_o              <= 1'b0;
        end else begin
            if (state == FETCH && enable_i) begin
                if (handshake) data_q <= sample_data_i;
                else if (tick) late_o <= 1'b1;
            end
            if (state == WRITE) begin
                if (full) begin
                    overrun_o <= 1'b1;
                end else begin
                    ADC_buffer_prod_out <= prod_inc;
                    sample_count_o      <= sample_count_o + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_buffer_sequencer.sv
// Directed bench for adc_buffer_sequencer with a 4-bit ring index.
module tb_adc_buffer_sequencer;

    localparam int ADC_BITS = 4;
    localparam int BA_BITS  = 32;
    localparam int DIV_BITS = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable_i, clear_i;
    logic [DIV_BITS-1:0] period_i;
    logic                sample_valid_i;
    logic [31:0]         sample_data_i;
    logic                sample_ready_o;
    logic [BA_BITS-1:0]  bram_addr_o;
    logic [31:0]         bram_din_o;
    logic                bram_en_o;
    logic [3:0]          bram_we_o;
    logic [ADC_BITS-1:0] prod;
    logic [ADC_BITS-1:0] cons;
    logic                overrun_o, late_o;
    logic [31:0]         sample_count_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ready_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    adc_buffer_sequencer #(
        .ADC_BITS(ADC_BITS), .BRAM_ADDR_BITS(BA_BITS), .DIV_BITS(DIV_BITS)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .clear_i(clear_i),
        .period_i(period_i), .sample_valid_i(sample_valid_i),
        .sample_data_i(sample_data_i), .sample_ready_o(sample_ready_o),
        .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o), .bram_en_o(bram_en_o),
        .bram_we_o(bram_we_o), .ADC_buffer_prod_out(prod),
        .ADC_buffer_cons_in(cons), .overrun_o(overrun_o), .late_o(late_o),
        .sample_count_o(sample_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every BRAM write and every ready cycle mid-period.
    always @(negedge clk) begin
        if (bram_en_o) begin
            wr_addr.push_back(bram_addr_o);
            wr_data.push_back(bram_din_o);
            wr_cyc.push_back(cyc);
        end
        if (sample_ready_o) ready_cnt <= ready_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        int n;
        int nwr;
        int rdy0;
        reset = 1'b0; enable_i = 1'b0; clear_i = 1'b0; period_i = '0;
        sample_valid_i = 1'b0; sample_data_i = '0; cons = '0;
        step(); step();
        check("rst_prod", 32'(prod), 0);
        check("rst_count", sample_count_o, 0);
        check("rst_flags", {30'd0, overrun_o, late_o}, 0);
        check("rst_en", 32'(bram_en_o), 0);
        check("rst_ready", 32'(sample_ready_o), 0);
        check("rst_we", 32'(bram_we_o), 0);

        // Period 3, always-valid source: one write every 4 cycles.
        reset = 1'b1;
        step();
        period_i = 16'd3; sample_valid_i = 1'b1; sample_data_i = 32'hCAFE_0001;
        enable_i = 1'b1;
        n = 0;
        while (wr_addr.size() < 3 && n < 60) begin step(); n++; end
        check("a_nwr", wr_addr.size(), 3);
        if (wr_addr.size() >= 3) begin
            check("a_addr0", wr_addr[0], 32'h0);
            check("a_addr1", wr_addr[1], 32'h4);
            check("a_addr2", wr_addr[2], 32'h8);
            check("a_data0", wr_data[0], 32'hCAFE_0001);
            check("a_gap1", wr_cyc[1] - wr_cyc[0], 4);
            check("a_gap2", wr_cyc[2] - wr_cyc[1], 4);
        end
        check("a_prod", 32'(prod), 3);
        check("a_count", sample_count_o, 3);
        enable_i = 1'b0;
        step(); step();

        // Fill to capacity: 15 writes, then overrun; freeing slots resumes at 0x3C.
        pulse_clear();
        check("b_clr_prod", 32'(prod), 0);
        check("b_clr_count", sample_count_o, 0);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        period_i = 16'd0; enable_i = 1'b1;
        n = 0;
        while (!overrun_o && n < 200) begin step(); n++; end
        check("b_overrun", 32'(overrun_o), 1);
        check("b_nwr", wr_addr.size(), 15);
        check("b_prod", 32'(prod), 15);
        if (wr_addr.size() == 15) check("b_last_addr", wr_addr[14], 32'h38);
        cons = 4'd5;
        n = 0;
        while (wr_addr.size() < 16 && n < 20) begin step(); n++; end
        check("b_resume_n", wr_addr.size(), 16);
        if (wr_addr.size() >= 16) check("b_resume_addr", wr_addr[15], 32'h3C);
        check("b_wrap_prod", 32'(prod), 0);
        check("b_count", sample_count_o, 16);
        check("b_sticky", 32'(overrun_o), 1);
        enable_i = 1'b0;
        step(); step();

        // Source stalls past a tick: late flag, then exactly one write.
        cons = 4'd0;
        pulse_clear();
        check("c_clr_ovr", 32'(overrun_o), 0);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        sample_valid_i = 1'b0; period_i = 16'd2; sample_data_i = 32'h1234_5678;
        enable_i = 1'b1;
        n = 0;
        while (!sample_ready_o && n < 20) begin step(); n++; end
        check("c_ready", 32'(sample_ready_o), 1);
        for (int i = 0; i < 5; i++) step();
        check("c_late", 32'(late_o), 1);
        check("c_nowr", wr_addr.size(), 0);
        check("c_still_ready", 32'(sample_ready_o), 1);
        sample_valid_i = 1'b1;
        step();
        sample_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("c_one_wr", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) check("c_data", wr_data[0], 32'h1234_5678);
        check("c_prod", 32'(prod), 1);

        // Clear in the same cycle as a write suppresses it.
        sample_valid_i = 1'b1;
        n = 0;
        while (!bram_en_o && n < 20) begin step(); n++; end
        check("d_in_write", 32'(bram_en_o), 1);
        nwr = wr_addr.size();
        clear_i = 1'b1; enable_i = 1'b0;
        #1;
        check("d_en_masked", 32'(bram_en_o), 0);
        step();
        clear_i = 1'b0;
        check("d_nwr", wr_addr.size(), nwr);
        check("d_prod", 32'(prod), 0);
        check("d_count", sample_count_o, 0);
        check("d_flags", {30'd0, overrun_o, late_o}, 0);

        // Reset while in FETCH with valid high: no handshake, all zero.
        period_i = 16'd3; sample_valid_i = 1'b1; enable_i = 1'b1;
        n = 0;
        while (!bram_en_o && n < 20) begin step(); n++; end
        sample_valid_i = 1'b0;
        step();
        check("e_prod1", 32'(prod), 1);
        n = 0;
        while (!sample_ready_o && n < 20) begin step(); n++; end
        check("e_fetch", 32'(sample_ready_o), 1);
        nwr = wr_addr.size();
        reset = 1'b0; sample_valid_i = 1'b1;
        #1;
        check("e_ready_masked", 32'(sample_ready_o), 0);
        step();
        check("e_prod", 32'(prod), 0);
        check("e_count", sample_count_o, 0);
        check("e_outs", {bram_en_o, bram_we_o, sample_ready_o, overrun_o, late_o}, 0);
        check("e_addr_din", bram_addr_o | bram_din_o, 0);
        enable_i = 1'b0;
        step();
        reset = 1'b1;
        step(); step();
        check("e_nwr", wr_addr.size(), nwr);
        check("e_idle_ready", 32'(sample_ready_o), 0);

        // Enable dropped during WRITE: the write completes, then idle.
        period_i = 16'd1; enable_i = 1'b1; sample_data_i = 32'hBEEF_0002;
        n = 0;
        while (!bram_en_o && n < 20) begin step(); n++; end
        nwr = wr_addr.size();
        enable_i = 1'b0;
        #1;
        check("f_en_kept", 32'(bram_en_o), 1);
        check("f_addr", bram_addr_o, 32'h0);
        check("f_din", bram_din_o, 32'hBEEF_0002);
        rdy0 = ready_cnt;
        step();
        check("f_prod", 32'(prod), 1);
        for (int i = 0; i < 6; i++) step();
        check("f_nwr", wr_addr.size(), nwr + 1);
        check("f_no_ready", ready_cnt - rdy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
